// File: rtl/dm_responder.sv
// Data-memory responder: byte-wide RAM serving the core port, with a host
// load/dump port whose ownership is arbitrated by a small handover FSM.
module dm_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr_dm,
  input  logic              dm_wr,
  input  logic [15:0]       to_mem,
  output logic [DATA_W-1:0] dm_in,
  output logic              core_run,
  input  logic              host_req,
  output logic              host_gnt,
  input  logic              host_valid,
  input  logic              host_wr,
  input  logic [15:0]       host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_CORE,
    S_DRAIN,
    S_HOST,
    S_RELEASE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DATA_W-1:0]     dm_in_q, dm_in_d;
  logic [DATA_W-1:0]     host_rdata_q, host_rdata_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic                  addr_err_q, addr_err_d;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  core_ok, host_ok;
  logic [15:0]           unused_to_mem;

  assign unused_to_mem = to_mem;
  assign core_ok = (addr_dm >> DEPTH_LOG2) == 16'd0;
  assign host_ok = (host_addr >> DEPTH_LOG2) == 16'd0;

  always_comb begin
    state_d       = state_q;
    dm_in_d       = dm_in_q;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;
    addr_err_d    = addr_err_q;
    mem_we        = 1'b0;
    mem_waddr     = addr_dm[DEPTH_LOG2-1:0];
    mem_wdata     = to_mem[DATA_W-1:0];
    core_run      = 1'b0;
    host_gnt      = 1'b0;

    case (state_q)
      S_CORE: begin
        core_run = 1'b1;
        if (host_req) state_d = S_DRAIN;
      end
      S_DRAIN:   state_d = S_HOST;
      S_HOST: begin
        host_gnt = 1'b1;
        if (!host_req) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_CORE;
      default:   state_d = S_CORE;
    endcase

    // DRAIN keeps the core port alive so a write from the last CORE cycle lands
    if (state_q == S_CORE || state_q == S_DRAIN) begin
      dm_in_d = core_ok ? mem_q[addr_dm[DEPTH_LOG2-1:0]] : '0;
      if (!core_ok) addr_err_d = 1'b1;
      if (dm_wr && core_ok) mem_we = 1'b1;
    end

    if (state_q == S_HOST && host_valid) begin
      if (!host_ok) addr_err_d = 1'b1;
      if (host_wr) begin
        mem_we    = host_ok;
        mem_waddr = host_addr[DEPTH_LOG2-1:0];
        mem_wdata = host_wdata;
      end else begin
        host_rvalid_d = 1'b1;
        host_rdata_d  = host_ok ? mem_q[host_addr[DEPTH_LOG2-1:0]] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_CORE;
      dm_in_q       <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dm_in_q       <= dm_in_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // RAM contents survive reset so preloaded data is kept across a core restart
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign dm_in       = dm_in_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a directed vector table for the main
// handover flow plus hand-written sequences for out-of-range, drain and reset.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr_dm = '0;
  logic        dm_wr = 1'b0;
  logic [15:0] to_mem = '0;
  logic [7:0]  dm_in;
  logic        core_run;
  logic        host_req = 1'b0;
  logic        host_gnt;
  logic        host_valid = 1'b0;
  logic        host_wr = 1'b0;
  logic [15:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        addr_err;

  int assertCount = 0;
  int failCount   = 0;

  dm_responder #(.DEPTH_LOG2(10), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_dm    (addr_dm),
    .dm_wr      (dm_wr),
    .to_mem     (to_mem),
    .dm_in      (dm_in),
    .core_run   (core_run),
    .host_req   (host_req),
    .host_gnt   (host_gnt),
    .host_valid (host_valid),
    .host_wr    (host_wr),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dm_wr;
    logic [15:0] addr_dm;
    logic [15:0] to_mem;
    logic        host_req;
    logic        host_valid;
    logic        host_wr;
    logic [15:0] host_addr;
    logic [7:0]  host_wdata;
    logic        chk_dm;
    logic [7:0]  exp_dm;
    logic        exp_run;
    logic        exp_gnt;
    logic        exp_rvalid;
    logic [7:0]  exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mkVec(
    input logic dw, input logic [15:0] ad, input logic [15:0] tm,
    input logic rq, input logic hv, input logic hw,
    input logic [15:0] ha, input logic [7:0] hd,
    input logic cd, input logic [7:0] edm, input logic er, input logic eg,
    input logic erv, input logic [7:0] erd, input logic ee);
    vec_t v;
    v.dm_wr = dw; v.addr_dm = ad; v.to_mem = tm;
    v.host_req = rq; v.host_valid = hv; v.host_wr = hw;
    v.host_addr = ha; v.host_wdata = hd;
    v.chk_dm = cd; v.exp_dm = edm; v.exp_run = er; v.exp_gnt = eg;
    v.exp_rvalid = erv; v.exp_rdata = erd; v.exp_err = ee;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one vector, clock one edge, then compare outputs just after it
  task automatic applyStimulus(input vec_t v, input string tag);
    dm_wr      = v.dm_wr;
    addr_dm    = v.addr_dm;
    to_mem     = v.to_mem;
    host_req   = v.host_req;
    host_valid = v.host_valid;
    host_wr    = v.host_wr;
    host_addr  = v.host_addr;
    host_wdata = v.host_wdata;
    @(posedge clk);
    #1;
    if (v.chk_dm) checkOutput({tag, " dm_in"}, 16'(dm_in), 16'(v.exp_dm));
    checkOutput({tag, " core_run"},    16'(core_run),    16'(v.exp_run));
    checkOutput({tag, " host_gnt"},    16'(host_gnt),    16'(v.exp_gnt));
    checkOutput({tag, " host_rvalid"}, 16'(host_rvalid), 16'(v.exp_rvalid));
    checkOutput({tag, " host_rdata"},  16'(host_rdata),  16'(v.exp_rdata));
    checkOutput({tag, " addr_err"},    16'(addr_err),    16'(v.exp_err));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " dm_in"},       16'(dm_in),       16'h0);
    checkOutput({tag, " host_rdata"},  16'(host_rdata),  16'h0);
    checkOutput({tag, " host_rvalid"}, 16'(host_rvalid), 16'h0);
    checkOutput({tag, " host_gnt"},    16'(host_gnt),    16'h0);
    checkOutput({tag, " core_run"},    16'(core_run),    16'h1);
    checkOutput({tag, " addr_err"},    16'(addr_err),    16'h0);
  endtask

  task automatic clearInputs();
    dm_wr = 1'b0; addr_dm = '0; to_mem = '0;
    host_req = 1'b0; host_valid = 1'b0; host_wr = 1'b0;
    host_addr = '0; host_wdata = '0;
  endtask

  initial begin
    //                 dw  addr     to_mem   rq hv hw haddr    hwd    cd edm    run gnt rv rdata  err
    vecs[0]  = mkVec(1, 16'h005, 16'h12A7, 0, 0, 0, 16'h000, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    vecs[1]  = mkVec(0, 16'h005, 16'h0000, 0, 0, 0, 16'h000, 8'h00, 1, 8'hA7, 1, 0, 0, 8'h00, 0);
    vecs[2]  = mkVec(0, 16'h005, 16'h0000, 1, 0, 0, 16'h000, 8'h00, 1, 8'hA7, 0, 0, 0, 8'h00, 0);
    vecs[3]  = mkVec(0, 16'h005, 16'h0000, 1, 0, 0, 16'h000, 8'h00, 1, 8'hA7, 0, 1, 0, 8'h00, 0);
    vecs[4]  = mkVec(0, 16'h005, 16'h0000, 1, 1, 1, 16'h000, 8'h11, 1, 8'hA7, 0, 1, 0, 8'h00, 0);
    vecs[5]  = mkVec(0, 16'h005, 16'h0000, 1, 1, 1, 16'h001, 8'h22, 1, 8'hA7, 0, 1, 0, 8'h00, 0);
    vecs[6]  = mkVec(0, 16'h005, 16'h0000, 1, 1, 1, 16'h002, 8'h33, 1, 8'hA7, 0, 1, 0, 8'h00, 0);
    vecs[7]  = mkVec(0, 16'h000, 16'h0000, 0, 0, 0, 16'h000, 8'h00, 1, 8'hA7, 0, 0, 0, 8'h00, 0);
    vecs[8]  = mkVec(0, 16'h000, 16'h0000, 0, 0, 0, 16'h000, 8'h00, 1, 8'hA7, 1, 0, 0, 8'h00, 0);
    vecs[9]  = mkVec(0, 16'h000, 16'h0000, 0, 0, 0, 16'h000, 8'h00, 1, 8'h11, 1, 0, 0, 8'h00, 0);
    vecs[10] = mkVec(0, 16'h001, 16'h0000, 0, 0, 0, 16'h000, 8'h00, 1, 8'h22, 1, 0, 0, 8'h00, 0);
    vecs[11] = mkVec(0, 16'h002, 16'h0000, 0, 0, 0, 16'h000, 8'h00, 1, 8'h33, 1, 0, 0, 8'h00, 0);
    vecs[12] = mkVec(1, 16'h3FF, 16'h005C, 0, 0, 0, 16'h000, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    vecs[13] = mkVec(0, 16'h3FF, 16'h0000, 1, 0, 0, 16'h000, 8'h00, 1, 8'h5C, 0, 0, 0, 8'h00, 0);
    vecs[14] = mkVec(0, 16'h3FF, 16'h0000, 1, 0, 0, 16'h000, 8'h00, 1, 8'h5C, 0, 1, 0, 8'h00, 0);
    vecs[15] = mkVec(0, 16'h3FF, 16'h0000, 1, 1, 0, 16'h3FF, 8'h00, 1, 8'h5C, 0, 1, 1, 8'h5C, 0);
    vecs[16] = mkVec(0, 16'h3FF, 16'h0000, 1, 0, 0, 16'h000, 8'h00, 1, 8'h5C, 0, 1, 0, 8'h5C, 0);
    vecs[17] = mkVec(0, 16'h3FF, 16'h0000, 0, 1, 0, 16'h000, 8'h00, 1, 8'h5C, 0, 0, 1, 8'h11, 0);
    vecs[18] = mkVec(0, 16'h3FF, 16'h0000, 0, 1, 0, 16'h001, 8'h00, 1, 8'h5C, 1, 0, 0, 8'h11, 0);
    vecs[19] = mkVec(0, 16'h3FF, 16'h0000, 0, 1, 0, 16'h002, 8'h00, 1, 8'h5C, 1, 0, 0, 8'h11, 0);

    #2 rst = 1'b1;
    #10;
    checkResetState("reset");
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 20; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Out-of-range core access: write dropped, read returns 0, flag sticks
    applyStimulus(mkVec(1, 16'h400, 16'h0077, 0, 0, 0, 16'h0, 8'h0, 0, 8'h00, 1, 0, 0, 8'h11, 1), "oor_wr");
    applyStimulus(mkVec(0, 16'h400, 16'h0000, 0, 0, 0, 16'h0, 8'h0, 1, 8'h00, 1, 0, 0, 8'h11, 1), "oor_rd");
    applyStimulus(mkVec(0, 16'h000, 16'h0000, 0, 0, 0, 16'h0, 8'h0, 1, 8'h11, 1, 0, 0, 8'h11, 1), "oor_ram0");
    for (int i = 0; i < 3; i++)
      applyStimulus(mkVec(0, 16'h000, 16'h0000, 0, 0, 0, 16'h0, 8'h0, 1, 8'h11, 1, 0, 0, 8'h11, 1),
                    $sformatf("oor_sticky%0d", i));
    clearInputs();
    rst = 1'b1;
    #1;
    checkResetState("reset2");
    @(posedge clk); #1 rst = 1'b0;

    // Drain boundary: writes in the last CORE cycle and in DRAIN land, HOST-time core writes do not
    applyStimulus(mkVec(1, 16'h009, 16'h003C, 1, 0, 0, 16'h0, 8'h0, 0, 8'h00, 0, 0, 0, 8'h00, 0), "drn_core");
    applyStimulus(mkVec(1, 16'h00A, 16'h004D, 1, 0, 0, 16'h0, 8'h0, 0, 8'h00, 0, 1, 0, 8'h00, 0), "drn_drain");
    applyStimulus(mkVec(1, 16'h009, 16'h00FF, 1, 0, 0, 16'h0, 8'h0, 0, 8'h00, 0, 1, 0, 8'h00, 0), "drn_hostwr");
    applyStimulus(mkVec(0, 16'h009, 16'h0000, 1, 1, 0, 16'h009, 8'h0, 0, 8'h00, 0, 1, 1, 8'h3C, 0), "drn_rd9");
    applyStimulus(mkVec(0, 16'h009, 16'h0000, 1, 1, 0, 16'h00A, 8'h0, 0, 8'h00, 0, 1, 1, 8'h4D, 0), "drn_rd10");
    applyStimulus(mkVec(0, 16'h009, 16'h0000, 1, 1, 1, 16'h00B, 8'hAB, 0, 8'h00, 0, 1, 0, 8'h4D, 0), "drn_wr11");
    applyStimulus(mkVec(0, 16'h009, 16'h0000, 1, 1, 0, 16'h00B, 8'h0, 0, 8'h00, 0, 1, 1, 8'hAB, 0), "drn_rd11");
    applyStimulus(mkVec(0, 16'h009, 16'h0000, 1, 1, 0, 16'h005, 8'h0, 0, 8'h00, 0, 1, 1, 8'hA7, 0), "drn_rd5");

    // Reset lands while a host read is still being driven
    host_addr = 16'h009;
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst host_rvalid", 16'(host_rvalid), 16'h0);
    checkOutput("midrst host_gnt",    16'(host_gnt),    16'h0);
    checkOutput("midrst core_run",    16'(core_run),    16'h1);
    checkOutput("midrst host_rdata",  16'(host_rdata),  16'h0);
    clearInputs();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst rvalid_after", 16'(host_rvalid), 16'h0);

    applyStimulus(mkVec(0, 16'h009, 16'h0, 0, 0, 0, 16'h0, 8'h0, 1, 8'h3C, 1, 0, 0, 8'h00, 0), "keep9");
    applyStimulus(mkVec(0, 16'h00A, 16'h0, 0, 0, 0, 16'h0, 8'h0, 1, 8'h4D, 1, 0, 0, 8'h00, 0), "keep10");
    applyStimulus(mkVec(0, 16'h005, 16'h0, 0, 0, 0, 16'h0, 8'h0, 1, 8'hA7, 1, 0, 0, 8'h00, 0), "keep5");
    applyStimulus(mkVec(0, 16'h000, 16'h0, 0, 0, 0, 16'h0, 8'h0, 1, 8'h11, 1, 0, 0, 8'h00, 0), "keep0");
    applyStimulus(mkVec(0, 16'h00B, 16'h0, 0, 0, 0, 16'h0, 8'h0, 1, 8'hAB, 1, 0, 0, 8'h00, 0), "keep11");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the core's data-memory interface. It accepts the core's address, write strobe and write data, and returns read data with fixed latency.
- Holds an internal byte-wide RAM.
- Adds a host load/dump port so matrices can be written before a run and results read back after it. Ownership arbitration between host and core is done by a small FSM that also gates the core run enable.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in bytes; legal range 4..16.
- DATA_W, 8, RAM word width; equals the core's dm_in width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addr_dm  in  16  core data address.
- dm_wr  in  1  core write strobe; sampled on rising edge.
- to_mem  in  16  core write data; only bits [DATA_W-1:0] are stored.
- dm_in  out  DATA_W  read data returned to the core.
- core_run  out  1  high while the core owns the RAM; the core stalls when low.
- host_req  in  1  level request for host ownership.
- host_gnt  out  1  high while the host owns the RAM.
- host_valid  in  1  host access strobe; valid only while host_gnt=1.
- host_wr  in  1  1=write, 0=read; qualified by host_valid.
- host_addr  in  16  host byte address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  one-cycle pulse marking host_rdata valid.
- addr_err  out  1  sticky out-of-range flag; cleared only by rst.

Behaviour:
- Reset values:
  - dm_in=0, host_rdata=0, host_rvalid=0.
  - host_gnt=0, core_run=1, addr_err=0.
  - FSM=CORE.
  - RAM contents are not reset.
- An address is in range when addr[15:DEPTH_LOG2]==0. Out-of-range behaviour:
  - Writes are dropped and set addr_err.
  - Reads return 0 and set addr_err.
- FSM states: CORE, DRAIN, HOST, RELEASE.
  - CORE: core_run=1, host_gnt=0. The core port is active.
    - Write: on an edge with dm_wr=1, RAM[addr_dm] <= to_mem[DATA_W-1:0].
    - Read: every cycle dm_in <= RAM[addr_dm], registered, 1-cycle latency.
    - Read-during-write to the same address returns the OLD data.
    - host_req=1 -> DRAIN.
  - DRAIN: core_run=0. The core port stays active for this one cycle so a write issued in the last CORE cycle still completes. Unconditional -> HOST.
  - HOST: core_run=0, host_gnt=1. The core port is ignored (dm_wr has no effect) and dm_in holds its last value.
    - host_valid=1 with host_wr=1: write RAM[host_addr].
    - host_valid=1 with host_wr=0: host_rdata <= RAM[host_addr], and host_rvalid pulses on the next cycle (1-cycle latency).
    - Back-to-back host accesses are allowed every cycle.
    - host_req=0 -> RELEASE, provided no read is pending in the same cycle. A read issued in the same cycle host_req falls still completes, and its rvalid is emitted in RELEASE.
  - RELEASE: host_gnt=0, core_run=0. host_valid is ignored. Unconditional -> CORE, where core_run=1 again.
- host_valid while host_gnt=0 is ignored and produces no rvalid.
- host_req toggling during DRAIN or RELEASE has no effect until the FSM returns to CORE or HOST respectively.
- Reset mid-operation:
  - Any access in flight is abandoned.
  - The FSM returns to CORE and host_rvalid is forced to 0.
  - A write strobe coincident with the reset assertion is not guaranteed to land.
- Handover latency:
  - host_req rise -> host_gnt high after 2 edges.
  - host_req fall -> core_run high after 2 edges.

Test Plan:
- Core write/read: rst, then dm_wr=1 with addr_dm=0x0005, to_mem=0x12A7 -> next cycle addr 5 read, dm_in=0xA7 one edge later. Upper byte is discarded.
- Host load then core run:
  - Raise host_req -> host_gnt=1 after 2 edges, core_run=0.
  - Host writes 0x11,0x22,0x33 to 0..2 on consecutive cycles.
  - Drop host_req -> core_run=1 after 2 edges; core reads 0..2 -> 0x11,0x22,0x33.
- Host dump: core writes 0x5C at 0x03FF. Then host reads 0x03FF -> host_rvalid single pulse one cycle later with host_rdata=0x5C.
- Out of range (DEPTH_LOG2=10):
  - Core writes 0x77 to 0x0400 -> addr_err=1 and RAM[0] is unchanged.
  - Core reads 0x0400 -> dm_in=0.
  - addr_err stays 1 until rst.
- Drain boundary: dm_wr=1 to addr 9 (data 0x3C) on the same edge host_req rises -> host read of addr 9 returns 0x3C. Then dm_wr during HOST to addr 9 with 0xFF -> a later read still returns 0x3C.
- Reset mid-host: assert rst while in HOST with a read pending -> host_rvalid=0, host_gnt=0, core_run=1, and RAM contents written earlier are preserved.
